// File: rtl/elevator_fsm.sv
// Four-floor elevator car controller: steps the car one floor per clock toward
// the requested floor, then holds the doors open for DOOR_CYCLES cycles.
module elevator_fsm #(
   parameter int unsigned DOOR_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] floor,
   output logic [1:0] cf,
   output logic       door_open,
   output logic       dir_up,
   output logic       dir_down
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DOOR = 2'd3
   } state_t;

   localparam logic [3:0] DWELL_LOAD = 4'(DOOR_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] cf_q, cf_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cf_q    <= 2'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cf_q    <= cf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cf_d    = cf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (floor > cf_q)      state_d = UP;
            else if (floor < cf_q) state_d = DOWN;
         end
         UP: begin
            if (floor > cf_q) begin
               cf_d = cf_q + 2'd1;
               if (cf_q + 2'd1 == floor) begin
                  state_d = DOOR;
                  cnt_d   = DWELL_LOAD;
               end
            end else if (floor == cf_q) begin
               state_d = DOOR;
               cnt_d   = DWELL_LOAD;
            end else begin
               state_d = DOWN;
            end
         end
         DOWN: begin
            if (floor < cf_q) begin
               cf_d = cf_q - 2'd1;
               if (cf_q - 2'd1 == floor) begin
                  state_d = DOOR;
                  cnt_d   = DWELL_LOAD;
               end
            end else if (floor == cf_q) begin
               state_d = DOOR;
               cnt_d   = DWELL_LOAD;
            end else begin
               state_d = UP;
            end
         end
         DOOR: begin
            // floor is deliberately ignored here; pending requests resume from IDLE
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cf        = cf_q;
   assign dir_up    = (state_q == UP);
   assign dir_down  = (state_q == DOWN);
   assign door_open = (state_q == DOOR);

endmodule

// File: tb/tb_elevator_fsm.sv
// Directed bench for elevator_fsm: each step advances one clock edge and
// compares {cf, dir_up, dir_down, door_open} against hand-computed values.
module tb_elevator_fsm;

   logic       clk;
   logic       rst;
   logic [1:0] floor;
   logic [1:0] cf;
   logic       door_open;
   logic       dir_up;
   logic       dir_down;

   int checks;
   int failures;

   elevator_fsm #(.DOOR_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .floor     (floor),
      .cf        (cf),
      .door_open (door_open),
      .dir_up    (dir_up),
      .dir_down  (dir_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input string tag, input logic [1:0] ecf,
                       input logic eu, input logic ed, input logic eo);
      logic [4:0] obs, exp;
      @(posedge clk);
      #1;
      obs = {cf, dir_up, dir_down, door_open};
      exp = {ecf, eu, ed, eo};
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed cf/up/down/door=%b required=%b", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      floor    = 2'd3;

      // Reset held with a pending request
      step("rst_0", 2'd0, 0, 0, 0);
      step("rst_1", 2'd0, 0, 0, 0);
      rst = 1'b0;

      // Up travel 0 -> 3
      step("up_e1", 2'd0, 1, 0, 0);
      step("up_e2", 2'd1, 1, 0, 0);
      step("up_e3", 2'd2, 1, 0, 0);
      step("up_e4", 2'd3, 0, 0, 1);
      step("up_dw", 2'd3, 0, 0, 1);
      step("up_idle", 2'd3, 0, 0, 0);
      step("same_floor", 2'd3, 0, 0, 0);

      // Down travel 3 -> 2, then floor change during the dwell is deferred
      floor = 2'd2;
      step("dn_e1", 2'd3, 0, 1, 0);
      step("dn_e2", 2'd2, 0, 0, 1);
      floor = 2'd1;
      step("door_ignore", 2'd2, 0, 0, 1);
      step("door_idle", 2'd2, 0, 0, 0);
      step("dn2_e1", 2'd2, 0, 1, 0);
      step("dn2_e2", 2'd1, 0, 0, 1);
      step("dn2_dw", 2'd1, 0, 0, 1);
      step("dn2_idle", 2'd1, 0, 0, 0);

      // Return to floor 0
      floor = 2'd0;
      step("ret_e1", 2'd1, 0, 1, 0);
      step("ret_e2", 2'd0, 0, 0, 1);
      step("ret_dw", 2'd0, 0, 0, 1);
      step("ret_idle", 2'd0, 0, 0, 0);

      // Mid-travel reversal at cf=2
      floor = 2'd3;
      step("rev_e1", 2'd0, 1, 0, 0);
      step("rev_e2", 2'd1, 1, 0, 0);
      step("rev_e3", 2'd2, 1, 0, 0);
      floor = 2'd0;
      step("rev_turn", 2'd2, 0, 1, 0);
      step("rev_dn1", 2'd1, 0, 1, 0);
      step("rev_arr", 2'd0, 0, 0, 1);
      step("rev_dw", 2'd0, 0, 0, 1);
      step("rev_idle", 2'd0, 0, 0, 0);

      // Retarget to the current floor while moving up
      floor = 2'd2;
      step("rt_e1", 2'd0, 1, 0, 0);
      step("rt_e2", 2'd1, 1, 0, 0);
      floor = 2'd1;
      step("rt_door", 2'd1, 0, 0, 1);
      step("rt_dw", 2'd1, 0, 0, 1);
      step("rt_idle", 2'd1, 0, 0, 0);

      // Reset asserted while moving up at cf=2
      floor = 2'd3;
      step("mr_e1", 2'd1, 1, 0, 0);
      step("mr_e2", 2'd2, 1, 0, 0);
      rst = 1'b1;
      step("mr_rst", 2'd0, 0, 0, 0);
      rst   = 1'b0;
      floor = 2'd0;
      step("mr_idle", 2'd0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
